// File: rtl/frame_stream_pkg.sv
// Shared types and constants for the frame streamer: FSM states, default header bytes, frame counter width.
package frame_stream_pkg;

  typedef enum logic [2:0] {
    IDLE,
    GUARD_PRE,
    HDR,
    FETCH,
    SEND,
    GUARD_POST
  } state_t;

  localparam logic [7:0] DEF_HDR_BYTE0 = 8'hA5;
  localparam logic [7:0] DEF_HDR_BYTE1 = 8'h5A;
  localparam int         FRAME_CNT_W   = 16;

endpackage

// File: rtl/vs_edge_sync.sv
// Two-flop synchroniser with rising-edge detect; rise is a one-cycle pulse 2-3 cycles after the input edge.
// No backpressure: every synchronised edge produces exactly one pulse.
module vs_edge_sync (
  input  logic clk,
  input  logic rst_n,
  input  logic din,
  output logic rise
);

  logic meta;
  logic sync;
  logic sync_d;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      meta   <= 1'b0;
      sync   <= 1'b0;
      sync_d <= 1'b0;
    end else begin
      meta   <= din;
      sync   <= meta;
      sync_d <= sync;
    end
  end

  assign rise = sync & ~sync_d;

endmodule

// File: rtl/frame_uart_streamer.sv
// Streams optional header plus one RAM frame to a UART Tx after each VSYNC edge, bracketed by guard intervals.
// Pixel byte = FETCH + SEND (2 cycles min); SEND holds valid/data until Tx ready.
module frame_uart_streamer
  import frame_stream_pkg::*;
#(
  parameter int         ADDR_W          = 15,
  parameter int         BYTES_PER_FRAME = 9216,
  parameter int         GUARD_CYCLES    = 62500000,
  parameter int         CNT_W           = 26,
  parameter bit         HDR_EN          = 1'b1,
  parameter logic [7:0] HDR_BYTE0       = DEF_HDR_BYTE0,
  parameter logic [7:0] HDR_BYTE1       = DEF_HDR_BYTE1
) (
  input  logic                   Clk,
  input  logic                   i_Rst_n,
  input  logic                   i_VS,
  input  logic                   i_Mode,
  input  logic                   i_Req,
  input  logic                   i_Abort,
  output logic [ADDR_W-1:0]      o_Rd_Addr,
  input  logic [7:0]             i_Rd_Data,
  output logic                   o_Tx_Valid,
  output logic [7:0]             o_Tx_Data,
  input  logic                   i_Tx_Ready,
  output logic                   o_Frame_Indicator,
  output logic                   o_Busy,
  output logic [FRAME_CNT_W-1:0] o_Frame_Count,
  output logic                   o_Overrun
);

  localparam logic [CNT_W-1:0]  GUARD_LAST = CNT_W'((GUARD_CYCLES > 1) ? GUARD_CYCLES - 1 : 0);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(BYTES_PER_FRAME - 1);

  state_t                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0]      addr_q, addr_d;
  logic                   hdr_sel_q, hdr_sel_d;
  logic [FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic                   overrun_q, overrun_d;
  logic                   pending_q, pending_d;
  logic                   vs_rise;
  logic                   xfer;

  vs_edge_sync u_vs_sync (
    .clk   (Clk),
    .rst_n (i_Rst_n),
    .din   (i_VS),
    .rise  (vs_rise)
  );

  assign o_Tx_Valid = (state_q == HDR) || (state_q == SEND);
  assign xfer       = o_Tx_Valid && i_Tx_Ready;

  // In SEND the RAM keeps re-reading a held address, so its output is already stable for the stall.
  always_comb begin
    o_Tx_Data = 8'h00;
    if (state_q == HDR)
      o_Tx_Data = hdr_sel_q ? HDR_BYTE1 : HDR_BYTE0;
    else if (state_q == SEND)
      o_Tx_Data = i_Rd_Data;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    hdr_sel_d   = hdr_sel_q;
    frame_cnt_d = frame_cnt_q;
    overrun_d   = overrun_q;
    pending_d   = pending_q;

    if (vs_rise && state_q != IDLE)
      overrun_d = 1'b1;

    if (i_Abort && state_q != IDLE) begin
      state_d   = IDLE;
      cnt_d     = '0;
      addr_d    = '0;
      hdr_sel_d = 1'b0;
      pending_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d = '0;
          if (i_Mode) begin
            if (vs_rise && (pending_q || i_Req)) begin
              state_d   = GUARD_PRE;
              pending_d = 1'b0;
            end else if (i_Req) begin
              pending_d = 1'b1;
            end
          end else if (vs_rise) begin
            state_d = GUARD_PRE;
          end
        end
        GUARD_PRE: begin
          if (cnt_q == GUARD_LAST) begin
            cnt_d     = '0;
            addr_d    = '0;
            hdr_sel_d = 1'b0;
            state_d   = HDR_EN ? HDR : FETCH;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        HDR: begin
          if (xfer) begin
            if (hdr_sel_q) begin
              hdr_sel_d = 1'b0;
              addr_d    = '0;
              state_d   = FETCH;
            end else begin
              hdr_sel_d = 1'b1;
            end
          end
        end
        FETCH: state_d = SEND;
        SEND: begin
          if (xfer) begin
            if (addr_q == LAST_ADDR) begin
              addr_d      = '0;
              frame_cnt_d = frame_cnt_q + 1'b1;
              cnt_d       = '0;
              state_d     = GUARD_POST;
            end else begin
              addr_d  = addr_q + 1'b1;
              state_d = FETCH;
            end
          end
        end
        GUARD_POST: begin
          if (cnt_q == GUARD_LAST) begin
            cnt_d   = '0;
            state_d = IDLE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge Clk) begin
    if (!i_Rst_n) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      hdr_sel_q   <= 1'b0;
      frame_cnt_q <= '0;
      overrun_q   <= 1'b0;
      pending_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      hdr_sel_q   <= hdr_sel_d;
      frame_cnt_q <= frame_cnt_d;
      overrun_q   <= overrun_d;
      pending_q   <= pending_d;
    end
  end

  assign o_Rd_Addr         = addr_q;
  assign o_Frame_Indicator = (state_q == IDLE);
  assign o_Busy            = (state_q != IDLE);
  assign o_Frame_Count     = frame_cnt_q;
  assign o_Overrun         = overrun_q;

endmodule

// File: doc/frame_uart_streamer.md
Name: frame_uart_streamer

Overview:
Parametrised successor to the camera-frame sender. After a VSYNC rising edge it waits a guard interval, then streams a frame from the frame RAM into the UART transmitter: an optional 2-byte header followed by BYTES_PER_FRAME pixel bytes. It then waits a trailing guard interval and returns to idle. Byte pacing uses a valid/ready handshake with the Tx block instead of fixed clock counts. It supports continuous and single-shot modes, abort, overrun flagging and a frame counter.

Parameters:
ADDR_W, 15, frame RAM address width
BYTES_PER_FRAME, 9216, pixel bytes per frame; must be ≤ 2^ADDR_W
GUARD_CYCLES, 62500000, length of the pre- and post-frame guard intervals, in Clk cycles
CNT_W, 26, guard counter width; must satisfy 2^CNT_W > GUARD_CYCLES
HDR_EN, 1, 1 = send header bytes before pixel data
HDR_BYTE0, 8'hA5, first header byte
HDR_BYTE1, 8'h5A, second header byte

Ports:
Clk  in  1  system clock
i_Rst_n  in  1  synchronous, active-low reset
i_VS  in  1  camera VSYNC, asynchronous to Clk
i_Mode  in  1  0 = stream every frame; 1 = single-shot on request
i_Req  in  1  single-shot request pulse (used only when i_Mode=1)
i_Abort  in  1  abort the current transfer
o_Rd_Addr  out  ADDR_W  frame RAM read address
i_Rd_Data  in  8  frame RAM read data, 1-cycle registered latency
o_Tx_Valid  out  1  byte available to Tx
o_Tx_Data  out  8  byte to transmit
i_Tx_Ready  in  1  Tx can accept a byte
o_Frame_Indicator  out  1  1 while in IDLE
o_Busy  out  1  1 in any state other than IDLE
o_Frame_Count  out  16  number of completed frames, wraps
o_Overrun  out  1  sticky flag: VS edge arrived while busy

Behaviour:
- Reset (i_Rst_n=0 at a Clk edge), all outputs and state:
  - state=IDLE, o_Rd_Addr=0, o_Tx_Valid=0, o_Tx_Data=0
  - o_Frame_Indicator=1, o_Busy=0, o_Frame_Count=0, o_Overrun=0
  - pending request cleared, synchroniser flops cleared
  - Reset in the middle of a transfer behaves the same; no partial byte is held.
- VS handling: i_VS passes through a 2-flop synchroniser, then rising-edge detect, giving a one-cycle vs_rise.
- Handshake: a byte transfers on a cycle where o_Tx_Valid=1 and i_Tx_Ready=1. While o_Tx_Valid=1, o_Tx_Data is stable and valid stays high until the transfer occurs.
- State machine:
  - IDLE:
    - i_Mode=0: vs_rise → GUARD_PRE.
    - i_Mode=1: i_Req sets pending; vs_rise with pending set → GUARD_PRE and clears pending. vs_rise with pending clear is ignored.
  - GUARD_PRE:
    - Lasts max(GUARD_CYCLES,1) cycles.
    - Then goes to HDR if HDR_EN=1, else FETCH with o_Rd_Addr=0.
  - HDR:
    - Presents HDR_BYTE0, then HDR_BYTE1, each under the handshake.
    - After the second transfer → FETCH with o_Rd_Addr=0.
  - FETCH: one cycle for RAM latency → SEND.
  - SEND:
    - Sets o_Tx_Valid=1 with o_Tx_Data=i_Rd_Data captured at FETCH exit.
    - On transfer, if o_Rd_Addr < BYTES_PER_FRAME-1: increment address → FETCH.
    - On transfer of the last byte: o_Rd_Addr←0, o_Frame_Count+1 → GUARD_POST.
  - GUARD_POST: lasts max(GUARD_CYCLES,1) cycles → IDLE.
- Abort:
  - i_Abort=1 in any non-IDLE state → IDLE on the next edge.
  - Clears o_Tx_Valid, o_Rd_Addr and pending; no frame count increment.
  - Abort takes priority over a simultaneous transfer.
- Overrun: vs_rise while state≠IDLE sets o_Overrun (sticky until reset). The edge is otherwise ignored; no queueing.
- Simultaneous events: vs_rise and i_Req in the same IDLE cycle in mode 1 starts the frame.
- Address width: the address never exceeds BYTES_PER_FRAME-1. o_Frame_Count wraps 65535→0.
- Throughput: with i_Tx_Ready held high, each pixel byte takes 2 cycles (FETCH+SEND).

Decomposition:
- Package frame_stream_pkg:
  - state enum {IDLE, GUARD_PRE, HDR, FETCH, SEND, GUARD_POST}
  - default header constants
  - FRAME_CNT_W=16
- Sub-module vs_edge_sync: 2-flop synchroniser plus rising-edge pulse, with the same clock/reset. Reusable for HS.

Test Plan (BYTES_PER_FRAME=4, GUARD_CYCLES=3, HDR_EN=1, RAM[i]=8'h10+i):
1. Mode 0, i_Tx_Ready=1, one VS pulse → bytes A5,5A,10,11,12,13 appear on o_Tx_Data in order; o_Frame_Count 0→1; o_Frame_Indicator returns to 1 three cycles after the last transfer.
2. i_Tx_Ready toggling 1/0 every cycle → o_Tx_Data stable while valid and not ready; byte sequence identical to scenario 1; no drops or duplicates.
3. Mode 1, VS pulse without i_Req → no transfers; then i_Req, then VS → one frame sent; a following VS without a new request → nothing sent.
4. Second VS pulse during SEND → o_Overrun=1 and stays 1; the current frame completes normally; o_Frame_Count=1.
5. i_Abort asserted after byte 11 transfers → next cycle IDLE, o_Tx_Valid=0, o_Rd_Addr=0, o_Frame_Count unchanged; the next VS sends a full frame starting from A5.
6. i_Rst_n=0 for 1 cycle mid-SEND → all outputs at reset values on the following cycle; o_Overrun=0, o_Frame_Count=0.
